mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port synchronous RAM (1-cycle read latency) between the core's instruction-fetch port and data port.
// - Sits between the core's MMU-facing interface and the on-chip RAM; replaces a dual-port memory on iCE40 builds.
// - Grants one access per cycle. Data accesses have priority; a starvation guard forces periodic fetch grants.
// - Counts contention cycles for performance debug.
// PARAMETERS
// ADDR_W        12  word-address width of RAM (byte address bits [ADDR_W+1:2] used)
// STARVE_LIMIT  4   max consecutive dm grants while if_req pending before if is forced (>=1)
// CNT_W         16  width of contention counter
// PORTS
// clk           in   1      clock, all state on rising edge
// resetb        in   1      reset, asynchronous, active-low
// if_req        in   1      fetch request; held with if_addr until if_gnt
// if_addr       in   32     fetch byte address ([1:0] ignored)
// if_gnt        out  1      fetch access issued to RAM this cycle (combinational)
// if_rvalid     out  1      if_rdata valid; exactly 1 cycle after if_gnt
// if_rdata      out  32     fetched word
// dm_req        in   1      data request; held with addr/we/be/wdata until dm_gnt
// dm_we         in   1      1 = write, 0 = read
// dm_be         in   4      byte-lane enables
// dm_addr       in   32     data byte address ([1:0] ignored; lanes via dm_be)
// dm_wdata      in   32     write data, lane-aligned
// dm_gnt        out  1      data access issued this cycle (combinational)
// dm_rvalid     out  1      completion, 1 cycle after dm_gnt (reads and writes)
// dm_rdata      out  32     raw read word (don't-care for writes)
// mem_en        out  1      RAM access enable
// mem_we        out  1      RAM write enable
// mem_be        out  4      RAM byte enables
// mem_addr      out  ADDR_W RAM word address
// mem_wdata     out  32     RAM write data
// mem_rdata     in   32     RAM read data, valid cycle after mem_en
// conflict_clr  in   1      synchronous clear of conflict_cnt
// conflict_cnt  out  CNT_W  cycles with if_req & dm_req both high, saturating
// BEHAVIOUR
// - Reset (resetb=0): if_gnt/dm_gnt/mem_en/mem_we=0, mem_be=0, rvalids=0, streak=0, conflict_cnt=0.
//   Outstanding response discarded; no rvalid after release.
// - Arbitration, per cycle:
//   - only one req -> that req granted.
//   - both -> dm granted unless streak==STARVE_LIMIT, then if granted.
//   - neither -> mem_en=0.
// - Streak counter (0..STARVE_LIMIT):
//   - +1 when dm granted while if_req=1.
//   - cleared when if granted or if_req=0.
//   - never exceeds STARVE_LIMIT.
// - Muxing:
//   - granted requester drives mem_addr=addr[ADDR_W+1:2], mem_we=dm_we&dm_gnt, mem_be.
//   - mem_be=dm_be for dm, 4'hF for if.
//   - mem_wdata=dm_wdata.
// - Response:
//   - owner register (NONE/IF/DM) captures grant.
//   - next cycle, owner's rvalid=1 and its rdata=mem_rdata. Other rvalid=0.
// - Pipelining: full throughput; a new grant may issue the same cycle the previous rvalid is presented.
// - Unused address bits above ADDR_W+1 ignored (aliasing); misalignment detection is the core's job.
// - conflict_cnt: +1 per cycle with both reqs high, saturates at all-ones; conflict_clr wins over increment (-> 0).
// - Requester dropping req before gnt: permitted, no access, no rvalid.
// TESTING
// - if_req only, if_addr=0x100, RAM[0x40]=0x00000013 -> if_gnt same cycle, mem_addr=0x040, if_rvalid+if_rdata=0x13 next cycle.
// - both reqs held 10 cycles, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; conflict_cnt=10.
// - dm write addr=0x8, be=4'b0011, wdata=0xAABBCCDD with if_req=1 -> mem_we=1, mem_be=0011, mem_addr=2, if_gnt=0, dm_rvalid next cycle;
//   readback gives lower half 0xCCDD.
// - CNT_W=4, both reqs 20 cycles -> conflict_cnt sticks at 0xF; conflict_clr with both reqs -> 0 next cycle.
// - resetb low the cycle after dm read grant -> dm_rvalid never asserted, streak=0, all outputs reset values.
// - alternating if/dm single requests each cycle -> 100% grant rate, each rvalid 1 cycle after its gnt, data routed to correct port.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between the instruction-fetch port and the data port. Data wins
// contention, except that a fetch is forced through after STARVE_LIMIT
// consecutive data grants made while a fetch was waiting. Cycles in which both
// ports request are counted in a saturating contention counter.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              resetb,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // contention counter
  input  logic              conflict_clr,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Which port owns the RAM response arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Address bits outside the RAM word index alias and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Grant decision: data first, fetch forced once the streak hits the limit.
  // Grants are held low while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (resetb) begin
      if (if_req && (!dm_req || (streak_q == LIMIT))) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // RAM request mux driven by whichever port was granted.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_we & dm_gnt;
    mem_be    = dm_gnt ? dm_be : (if_gnt ? 4'hF : 4'h0);
    mem_addr  = dm_gnt ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
    mem_wdata = dm_wdata;
  end

  // Next-state for streak, response owner and contention counter.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q != LIMIT)) begin
      streak_d = streak_q + SW'(1);
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt) begin
      owner_d = OWN_DM;
    end

    cnt_d = cnt_q;
    if (conflict_clr) begin
      cnt_d = '0;
    end else if (if_req && dm_req) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      cnt_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
    end
  end

  // Response routing: RAM data goes to both ports, valid only to the owner.
  always_comb begin
    if_rvalid    = (owner_q == OWN_IF);
    dm_rvalid    = (owner_q == OWN_DM);
    if_rdata     = mem_rdata;
    dm_rdata     = mem_rdata;
    conflict_cnt = cnt_q;
  end

endmodule
